// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: fills a 256x8 S memory with the identity permutation,
// then runs the KSA swap loop with a KEY_LENGTH-byte key captured at start.
module rc4_ksa_engine #(
    parameter int KEY_LENGTH = 3,
    parameter int RD_LATENCY = 1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    output logic [7:0]              mem_address,
    output logic [7:0]              mem_data,
    output logic                    mem_wren,
    input  logic [7:0]              mem_q,
    output logic                    busy,
    output logic                    init_done,
    output logic                    done,
    output logic [3:0]              dbg_state
);

    localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_RD_I   = 4'd2,
        S_WAIT_I = 4'd3,
        S_RD_J   = 4'd4,
        S_WAIT_J = 4'd5,
        S_WR_I   = 4'd6,
        S_WR_J   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              i_q, i_d;
    logic [7:0]              j_q, j_d;
    logic [7:0]              si_q, si_d;
    logic [7:0]              sj_q, sj_d;
    logic [KW-1:0]           kidx_q, kidx_d;
    logic [8*KEY_LENGTH-1:0] key_q, key_d;
    logic                    wcnt_q, wcnt_d;
    logic                    init_done_q, init_done_d;

    logic [7:0] key_byte;
    logic [7:0] j_sum;
    logic       wait_last;

    // Key byte 0 sits in the most significant byte of the captured key.
    assign key_byte  = key_q[8*(KEY_LENGTH-1-int'(kidx_q)) +: 8];
    assign j_sum     = j_q + mem_q + key_byte;
    assign wait_last = (int'(wcnt_q) == RD_LATENCY - 1);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            kidx_q      <= '0;
            key_q       <= '0;
            wcnt_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            kidx_q      <= kidx_d;
            key_q       <= key_d;
            wcnt_q      <= wcnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Handshake: start is honoured only in IDLE/DONE; abort returns to IDLE from
    // any state on the next edge and overrides a simultaneous start.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        kidx_d      = kidx_q;
        key_d       = key_q;
        wcnt_d      = wcnt_q;
        init_done_d = init_done_q;
        mem_address = 8'd0;
        mem_data    = 8'd0;
        mem_wren    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_INIT;
                    key_d       = secret_key;
                    i_d         = 8'd0;
                    j_d         = 8'd0;
                    kidx_d      = '0;
                    init_done_d = 1'b0;
                end
            end
            S_INIT: begin
                mem_address = i_q;
                mem_data    = i_q;
                mem_wren    = 1'b1;
                i_d         = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    init_done_d = 1'b1;
                    state_d     = S_RD_I;
                end
            end
            S_RD_I: begin
                mem_address = i_q;
                wcnt_d      = 1'b0;
                state_d     = S_WAIT_I;
            end
            S_WAIT_I: begin
                mem_address = i_q;
                if (wait_last) begin
                    si_d    = mem_q;
                    j_d     = j_sum;
                    state_d = S_RD_J;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_RD_J: begin
                mem_address = j_q;
                wcnt_d      = 1'b0;
                state_d     = S_WAIT_J;
            end
            S_WAIT_J: begin
                mem_address = j_q;
                if (wait_last) begin
                    sj_d    = mem_q;
                    state_d = S_WR_I;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_WR_I: begin
                mem_address = i_q;
                mem_data    = sj_q;
                mem_wren    = 1'b1;
                state_d     = S_WR_J;
            end
            S_WR_J: begin
                mem_address = j_q;
                mem_data    = si_q;
                mem_wren    = 1'b1;
                kidx_d      = (kidx_q == KW'(KEY_LENGTH - 1)) ? '0 : kidx_q + 1'b1;
                i_d         = i_q + 8'd1;
                state_d     = (i_q == 8'hFF) ? S_DONE : S_RD_I;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            init_done_d = 1'b0;
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign init_done = init_done_q;
    assign dbg_state = state_q;

endmodule
